// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and bit-timing helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Clock cycles per serial bit; truncating division, shared with the receiver.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO. rdata always shows the head entry.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed, contents are only read once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed 8N1-style framer, start/data(LSB first)/stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 27000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          serial_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  uart_state_e              state;
  logic [CW-1:0]            cyc_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [PAYLOAD_BITS-1:0]  shift;
  logic [PAYLOAD_BITS-1:0]  shift_nxt;
  logic [PAYLOAD_BITS-1:0]  fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     bit_end;

  assign tx_ready  = !fifo_full;
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (cyc_cnt == CW'(CPB - 1));
  // Pop when idle, or on the last stop-bit cycle so frames run back-to-back.
  assign pop       = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign shift_nxt = shift >> 1;
  assign tx_busy   = (state != IDLE);

  sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame FSM with registered line output, bit-period and bit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      serial_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          serial_tx <= 1'b1;
          cyc_cnt   <= '0;
          if (pop) begin
            shift     <= fifo_rdata;
            bit_cnt   <= '0;
            serial_tx <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_cnt   <= '0;
            serial_tx <= shift[0];
            state     <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BW'(PAYLOAD_BITS - 1)) begin
              serial_tx <= 1'b1;
              state     <= STOP;
            end else begin
              shift     <= shift_nxt;
              bit_cnt   <= bit_cnt + BW'(1);
              serial_tx <= shift_nxt[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (pop) begin
              shift     <= fifo_rdata;
              bit_cnt   <= '0;
              serial_tx <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          serial_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle,
// directed scenarios with literal expectations, and a sampling receiver.
module tb_uart_tx_fifo;

  localparam int CLK_HZ   = 100;
  localparam int BIT_RATE = 10;
  localparam int PB       = 8;
  localparam int DEPTH    = 4;
  localparam int CPB      = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       serial_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (PB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_tx  (serial_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: queued words, plus the remaining line samples of the current frame.
  byte unsigned mq[$];
  bit           lq[$];
  bit           m_rdy;
  byte unsigned m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      lq.delete();
    end else begin
      m_rdy = (mq.size() != DEPTH);
      if (lq.size() != 0) void'(lq.pop_front());
      if (lq.size() == 0 && mq.size() != 0) begin
        m_w = mq.pop_front();
        for (int c = 0; c < CPB; c++) lq.push_back(1'b0);
        for (int b = 0; b < PB; b++)
          for (int c = 0; c < CPB; c++) lq.push_back(m_w[b]);
        for (int c = 0; c < CPB; c++) lq.push_back(1'b1);
      end
      if (tx_valid && m_rdy) mq.push_back(tx_data);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("line", serial_tx, (lq.size() != 0) ? lq[0] : 1'b1);
    chk("busy", tx_busy, lq.size() != 0);
    chk("count", fifo_count, mq.size());
    chk("ready", tx_ready, mq.size() != DEPTH);
  end

  // Sampling receiver: detect start, sample mid-bit, check stop.
  bit           rx_en = 1'b0;
  byte unsigned rx_q[$];
  logic [7:0]   rx_b;
  int           rx_ferr = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && !serial_tx) begin
        repeat (CPB / 2) @(negedge clk);
        if (!serial_tx) begin
          for (int k = 0; k < PB; k++) begin
            repeat (CPB) @(negedge clk);
            rx_b[k] = serial_tx;
          end
          repeat (CPB) @(negedge clk);
          if (serial_tx) rx_q.push_back(rx_b);
          else rx_ferr++;
        end else begin
          rx_ferr++;
        end
      end
    end
  end

  // Offer one word and hold it until an edge where tx_ready was high.
  task automatic send(input logic [7:0] d);
    bit ok;
    int n;
    tx_valid = 1'b1;
    tx_data  = d;
    n = 0;
    do begin
      ok = tx_ready;
      step(1);
      n++;
    end while (!ok && n < 5000);
    tx_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while ((tx_busy || fifo_count != 0) && n < limit) begin
      step(1);
      n++;
    end
    chk(name, tx_busy || fifo_count != 0, 0);
  endtask

  bit exp_a5[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int gaps;
  int lows;
  int n;

  initial begin
    // Reset state
    step(2);
    chk("rst_line", serial_tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    step(1);

    // Single 0xA5: latency, bit pattern, 100-cycle busy window
    send(8'hA5);                       // now E0+1
    chk("a5_count_e0", fifo_count, 1);
    step(1);                           // E1
    chk("a5_line_e1", serial_tx, 0);
    chk("a5_count_e1", fifo_count, 0);
    chk("a5_busy_e1", tx_busy, 1);
    step(4);                           // E5: middle of start bit
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("a5_bit%0d", k), serial_tx, exp_a5[k]);
      if (k < 9) step(10);
    end                                // E95
    step(5);                           // E100
    chk("a5_busy_e100", tx_busy, 1);
    step(1);                           // E101
    chk("a5_busy_e101", tx_busy, 0);
    chk("a5_line_e101", serial_tx, 1);
    step(3);

    // Four words back-to-back: contiguous 400-cycle busy window
    send(8'h00);                       // E0
    send(8'hFF);                       // E1 (first word popped here)
    send(8'h55);
    send(8'h0F);                       // E3
    chk("b2b_count", fifo_count, 3);
    chk("b2b_ready", tx_ready, 1);
    gaps = 0;
    for (int i = 0; i < 397; i++) begin
      step(1);
      if (!tx_busy) gaps++;
    end                                // E400
    chk("b2b_gaps", gaps, 0);
    chk("b2b_busy_e400", tx_busy, 1);
    step(1);
    chk("b2b_busy_e401", tx_busy, 0);
    step(3);

    // Full FIFO with tx_valid held high
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step(5);                           // E4: 4 queued
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    step(50);
    chk("full_hold_count", fifo_count, 4);
    n = 0;
    while (fifo_count != 3 && n < 200) begin
      step(1);
      n++;
    end
    chk("full_pop_seen", fifo_count, 3);
    step(1);
    chk("full_one_push", fifo_count, 4);
    chk("full_ready2", tx_ready, 0);
    tx_valid = 1'b0;
    wait_drain(1500, "full_drain");
    step(3);

    // Reset mid-DATA with two words queued
    send(8'hA5);
    send(8'h11);
    send(8'h22);                       // E2
    chk("rst_q_count", fifo_count, 2);
    step(30);                          // inside DATA
    chk("rst_pre_busy", tx_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", serial_tx, 1);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_ready", tx_ready, 1);
    step(2);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!serial_tx || tx_busy) lows++;
    end
    chk("rst_after_quiet", lows, 0);

    // Stream 0x00..0xFF with random gaps through the sampling receiver
    rx_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      step($urandom_range(0, 3));
    end
    n = 0;
    while (rx_q.size() < 256 && n < 3000) begin
      step(1);
      n++;
    end
    chk("rx_count", rx_q.size(), 256);
    chk("rx_framing", rx_ferr, 0);
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      chk($sformatf("rx_byte%0d", i), rx_q[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
